// File: rtl/core_exec_operand_stage.sv
// Decode-to-execute operand stage: scoreboard-driven forwarding, load-use stall
// detection and a registered operand output behind a valid/ready handshake.
module core_exec_operand_stage #(
    parameter int XLEN       = 32,
    parameter int STAGES     = 4,
    parameter int LOAD_STAGE = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [4:0]               i_rs1,
    input  logic [4:0]               i_rs2,
    input  logic [4:0]               i_rd,
    input  logic                     i_rd_wr,
    input  logic                     i_late,
    input  logic [XLEN-1:0]          i_rs1_val,
    input  logic [XLEN-1:0]          i_rs2_val,
    input  logic                     i_alu_op1_sel,
    input  logic                     i_alu_op2_sel,
    input  logic [XLEN-3:0]          i_pc,
    input  logic [XLEN-1:0]          i_imm,
    input  logic [STAGES*XLEN-1:0]   i_stage_val,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [XLEN-1:0]          o_op1,
    output logic [XLEN-1:0]          o_op2,
    output logic [XLEN-1:0]          o_bp1,
    output logic [XLEN-1:0]          o_bp2,
    output logic [4:0]               o_rd,
    output logic                     o_rd_wr,
    output logic                     o_late,
    output logic                     o_hazard
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, bp1_q, bp1_d, bp2_q, bp2_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_wr_q, rd_wr_d, late_q, late_d;

    logic [STAGES-1:1] sb_vld_q, sb_vld_d, sb_wr_q, sb_wr_d, sb_late_q, sb_late_d;
    logic [4:0]        sb_rd_q [1:STAGES-1];
    logic [4:0]        sb_rd_d [1:STAGES-1];

    logic [STAGES-1:0] ent_vld, ent_wr, ent_late;
    logic [4:0]        ent_rd [STAGES];

    logic [4:0]      src_rs  [2];
    logic [XLEN-1:0] src_rf  [2];
    logic [XLEN-1:0] fwd_val [2];
    logic [1:0]      fwd_haz;
    logic            hazard, capture;

    // Entry 0 of the scoreboard is the output register itself.
    always_comb begin
        ent_vld   = {sb_vld_q, valid_q};
        ent_wr    = {sb_wr_q, rd_wr_q};
        ent_late  = {sb_late_q, late_q};
        ent_rd[0] = rd_q;
        for (int k = 1; k < STAGES; k++) begin
            ent_rd[k] = sb_rd_q[k];
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        src_rs[0] = i_rs1;
        src_rs[1] = i_rs2;
        src_rf[0] = i_rs1_val;
        src_rf[1] = i_rs2_val;
        fwd_haz   = '0;
        for (int s = 0; s < 2; s++) begin
            fwd_val[s] = src_rf[s];
            if (src_rs[s] == 5'd0) begin
                fwd_val[s] = '0;
            end else begin
                for (int k = STAGES - 1; k >= 0; k--) begin
                    if (ent_vld[k] && ent_wr[k] && (ent_rd[k] != 5'd0) && (ent_rd[k] == src_rs[s])) begin
                        fwd_val[s] = i_stage_val[k*XLEN +: XLEN];
                        fwd_haz[s] = ent_late[k] && (k < LOAD_STAGE);
                    end
                end
            end
        end
    end

    assign hazard  = |fwd_haz;
    assign o_ready = (!valid_q || i_ready) && !hazard && !i_flush;
    assign capture = i_valid && o_ready;

    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        bp1_d   = bp1_q;
        bp2_d   = bp2_q;
        rd_d    = rd_q;
        rd_wr_d = rd_wr_q;
        late_d  = late_q;
        if (capture) begin
            valid_d = 1'b1;
            bp1_d   = fwd_val[0];
            bp2_d   = fwd_val[1];
            op1_d   = i_alu_op1_sel ? {i_pc, 2'b00} : fwd_val[0];
            op2_d   = i_alu_op2_sel ? i_imm : fwd_val[1];
            rd_d    = i_rd;
            rd_wr_d = i_rd_wr;
            late_d  = i_late;
        end else if (!valid_q || i_ready || i_flush) begin
            valid_d = 1'b0;
        end
    end

    // A flushed instruction still shifts in as valid: it is older than the flush source.
    always_comb begin
        sb_vld_d  = sb_vld_q;
        sb_wr_d   = sb_wr_q;
        sb_late_d = sb_late_q;
        sb_rd_d   = sb_rd_q;
        if (i_ready) begin
            sb_vld_d[1]  = valid_q;
            sb_wr_d[1]   = rd_wr_q;
            sb_late_d[1] = late_q;
            sb_rd_d[1]   = rd_q;
            for (int k = 2; k < STAGES; k++) begin
                sb_vld_d[k]  = sb_vld_q[k-1];
                sb_wr_d[k]   = sb_wr_q[k-1];
                sb_late_d[k] = sb_late_q[k-1];
                sb_rd_d[k]   = sb_rd_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            bp1_q    <= '0;
            bp2_q    <= '0;
            rd_q     <= '0;
            rd_wr_q  <= 1'b0;
            late_q   <= 1'b0;
            sb_vld_q <= '0;
        end else begin
            valid_q  <= valid_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            bp1_q    <= bp1_d;
            bp2_q    <= bp2_d;
            rd_q     <= rd_d;
            rd_wr_q  <= rd_wr_d;
            late_q   <= late_d;
            sb_vld_q <= sb_vld_d;
        end
    end

    always_ff @(posedge i_clk) begin
        sb_wr_q   <= sb_wr_d;
        sb_late_q <= sb_late_d;
        sb_rd_q   <= sb_rd_d;
    end

    assign o_valid  = valid_q;
    assign o_op1    = op1_q;
    assign o_op2    = op2_q;
    assign o_bp1    = bp1_q;
    assign o_bp2    = bp2_q;
    assign o_rd     = rd_q;
    assign o_rd_wr  = rd_wr_q;
    assign o_late   = late_q;
    assign o_hazard = hazard;

endmodule

// File: tb/tb_core_exec_operand_stage.sv
// Directed bench for core_exec_operand_stage; captured operands are checked
// against an expectation queue filled when each instruction is offered.
module tb_core_exec_operand_stage;

    localparam int XLEN = 32;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              i_reset, i_flush, i_valid, o_ready;
    logic [4:0]        i_rs1, i_rs2, i_rd;
    logic              i_rd_wr, i_late;
    logic [XLEN-1:0]   i_rs1_val, i_rs2_val;
    logic              i_alu_op1_sel, i_alu_op2_sel;
    logic [XLEN-3:0]   i_pc;
    logic [XLEN-1:0]   i_imm;
    logic [STAGES*XLEN-1:0] i_stage_val;
    logic              i_ready, o_valid;
    logic [XLEN-1:0]   o_op1, o_op2, o_bp1, o_bp2;
    logic [4:0]        o_rd;
    logic              o_rd_wr, o_late, o_hazard;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] bp1;
        logic [31:0] bp2;
        logic [4:0]  rd;
        logic        rd_wr;
        logic        late;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    core_exec_operand_stage #(.XLEN(XLEN), .STAGES(STAGES), .LOAD_STAGE(2)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_rd_wr(i_rd_wr), .i_late(i_late), .i_rs1_val(i_rs1_val),
        .i_rs2_val(i_rs2_val), .i_alu_op1_sel(i_alu_op1_sel),
        .i_alu_op2_sel(i_alu_op2_sel), .i_pc(i_pc), .i_imm(i_imm),
        .i_stage_val(i_stage_val), .i_ready(i_ready), .o_valid(o_valid),
        .o_op1(o_op1), .o_op2(o_op2), .o_bp1(o_bp1), .o_bp2(o_bp2),
        .o_rd(o_rd), .o_rd_wr(o_rd_wr), .o_late(o_late), .o_hazard(o_hazard)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wr, input logic late, input logic [31:0] v1,
                         input logic [31:0] v2, input logic s1, input logic s2,
                         input logic [29:0] pc, input logic [31:0] imm);
        i_valid = 1'b1;
        i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_rd_wr = wr; i_late = late;
        i_rs1_val = v1; i_rs2_val = v2;
        i_alu_op1_sel = s1; i_alu_op2_sel = s2; i_pc = pc; i_imm = imm;
    endtask

    task automatic slices(input logic [31:0] s0, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] s3);
        i_stage_val = {s3, s2, s1, s0};
    endtask

    task automatic push(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] bp1,
                        input logic [31:0] bp2, input logic [4:0] rd, input logic wr,
                        input logic late);
        exp_t e;
        e = '{op1: op1, op2: op2, bp1: bp1, bp2: bp2, rd: rd, rd_wr: wr, late: late};
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".queued"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ".op1"}, o_op1, e.op1);
            chk({tag, ".op2"}, o_op2, e.op2);
            chk({tag, ".bp1"}, o_bp1, e.bp1);
            chk({tag, ".bp2"}, o_bp2, e.bp2);
            chk({tag, ".rd"}, 32'(o_rd), 32'(e.rd));
            chk({tag, ".rd_wr"}, 32'(o_rd_wr), 32'(e.rd_wr));
            chk({tag, ".late"}, 32'(o_late), 32'(e.late));
        end
    endtask

    task automatic simple_issue(input string tag, input logic [4:0] rd, input logic [31:0] imm);
        drive(5'd0, 5'd0, rd, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 30'h0, imm);
        push(32'h0, imm, 32'h0, 32'h0, rd, 1'b1, 1'b0);
        tick();
        check_out(tag);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0);
        i_valid = 1'b0;
        slices(32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.op1", o_op1, 32'h0);
        chk("rst.op2", o_op2, 32'h0);
        chk("rst.bp1", o_bp1, 32'h0);
        chk("rst.bp2", o_bp2, 32'h0);
        chk("rst.rd", 32'(o_rd), 32'h0);
        chk("rst.rd_wr", 32'(o_rd_wr), 32'h0);
        chk("rst.late", 32'(o_late), 32'h0);
        chk("rst.hazard", 32'(o_hazard), 32'h0);
        i_reset = 1'b0;
        #1 chk("rst.ready", 32'(o_ready), 32'd1);

        // ALU chain: addi x5,x0,0x10 then add x6,x5,x5 forwarded from slice 0
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h55, 32'h66, 1'b0, 1'b1, 30'h0, 32'h10);
        push(32'h0, 32'h10, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0);
        #1 chk("alu_a.ready", 32'(o_ready), 32'd1);
        tick();
        check_out("alu_a");
        slices(32'h10, 32'h0, 32'h0, 32'h0);
        drive(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 32'hBAD, 32'hBAD, 1'b0, 1'b0, 30'h0, 32'h0);
        push(32'h10, 32'h10, 32'h10, 32'h10, 5'd6, 1'b1, 1'b0);
        #1 chk("alu_b.hazard", 32'(o_hazard), 32'd0);
        chk("alu_b.ready", 32'(o_ready), 32'd1);
        tick();
        check_out("alu_b");
        i_valid = 1'b0;
        tick();
        chk("bubble.valid", 32'(o_valid), 32'd0);
        slices(32'h0, 32'h0, 32'h0, 32'h0);
        drain();

        // Load-use: lw x7 then add x8,x7,x0 stalls two cycles
        drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 30'h0, 32'h4);
        push(32'h0, 32'h4, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1);
        tick();
        check_out("lw");
        slices(32'h99, 32'h98, 32'hDEADBEEF, 32'h97);
        drive(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h1111, 32'h2222, 1'b0, 1'b0, 30'h0, 32'h0);
        push(32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 5'd8, 1'b1, 1'b0);
        #1 chk("lu.haz1", 32'(o_hazard), 32'd1);
        chk("lu.ready1", 32'(o_ready), 32'd0);
        tick();
        chk("lu.bubble", 32'(o_valid), 32'd0);
        chk("lu.haz2", 32'(o_hazard), 32'd1);
        tick();
        chk("lu.haz3", 32'(o_hazard), 32'd0);
        chk("lu.ready3", 32'(o_ready), 32'd1);
        tick();
        check_out("lu_dep");
        slices(32'h0, 32'h0, 32'h0, 32'h0);
        drain();

        // Priority: x9 at stages 1 and 3, youngest wins; x0 never forwards
        simple_issue("pr1", 5'd9, 32'h1);
        simple_issue("pr2", 5'd3, 32'h2);
        simple_issue("pr3", 5'd9, 32'h3);
        simple_issue("pr4", 5'd0, 32'h4);
        slices(32'h70, 32'h1, 32'h72, 32'h3);
        drive(5'd9, 5'd0, 5'd12, 1'b1, 1'b0, 32'hEE, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0);
        push(32'h1, 32'h0, 32'h1, 32'h0, 5'd12, 1'b1, 1'b0);
        tick();
        check_out("prio");
        slices(32'h80, 32'h81, 32'h22, 32'h83);
        drive(5'd0, 5'd9, 5'd13, 1'b1, 1'b0, 32'h77, 32'hEE, 1'b0, 1'b0, 30'h0, 32'h0);
        push(32'h0, 32'h22, 32'h0, 32'h22, 5'd13, 1'b1, 1'b0);
        tick();
        check_out("x0");

        // PC / immediate select with rs2 forwarded from stage 3
        slices(32'h90, 32'h91, 32'h92, 32'h33);
        drive(5'd5, 5'd9, 5'd14, 1'b1, 1'b0, 32'hAAAA, 32'hEE, 1'b1, 1'b1, 30'h100, 32'h24);
        push(32'h400, 32'h24, 32'hAAAA, 32'h33, 5'd14, 1'b1, 1'b0);
        tick();
        check_out("pcimm");

        // Downstream stall for three cycles, then flush
        i_ready = 1'b0;
        drive(5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 30'h0, 32'h5);
        #1 chk("stall.ready", 32'(o_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall.valid", 32'(o_valid), 32'd1);
            chk("stall.op1", o_op1, 32'h400);
            chk("stall.op2", o_op2, 32'h24);
            chk("stall.rd", 32'(o_rd), 32'd14);
        end
        i_flush = 1'b1;
        i_ready = 1'b1;
        #1 chk("flush.ready", 32'(o_ready), 32'd0);
        tick();
        chk("flush.valid", 32'(o_valid), 32'd0);
        i_flush = 1'b0;
        slices(32'hA0, 32'h5151, 32'h6262, 32'hA3);
        drive(5'd14, 5'd13, 5'd16, 1'b1, 1'b0, 32'h1, 32'h2, 1'b0, 1'b0, 30'h0, 32'h0);
        push(32'h5151, 32'h6262, 32'h5151, 32'h6262, 5'd16, 1'b1, 1'b0);
        tick();
        check_out("post_flush");

        // Reset while a load-use hazard is pending
        slices(32'h0, 32'h0, 32'h0, 32'h0);
        drive(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 30'h0, 32'h8);
        push(32'h0, 32'h8, 32'h0, 32'h0, 5'd20, 1'b1, 1'b1);
        tick();
        check_out("ld2");
        drive(5'd20, 5'd0, 5'd21, 1'b1, 1'b0, 32'h2020, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0);
        #1 chk("rh.haz", 32'(o_hazard), 32'd1);
        i_reset = 1'b1;
        tick();
        chk("rh.valid", 32'(o_valid), 32'd0);
        chk("rh.op1", o_op1, 32'h0);
        chk("rh.op2", o_op2, 32'h0);
        chk("rh.bp1", o_bp1, 32'h0);
        chk("rh.bp2", o_bp2, 32'h0);
        chk("rh.rd", 32'(o_rd), 32'h0);
        chk("rh.rd_wr", 32'(o_rd_wr), 32'h0);
        chk("rh.late", 32'(o_late), 32'h0);
        chk("rh.hazard", 32'(o_hazard), 32'h0);
        i_reset = 1'b0;
        push(32'h2020, 32'h0, 32'h2020, 32'h0, 5'd21, 1'b1, 1'b0);
        #1 chk("rh.ready", 32'(o_ready), 32'd1);
        tick();
        check_out("after_rst");
        i_valid = 1'b0;
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/core_exec_operand_stage.md
# core_exec_operand_stage

Registered operand-preparation stage at the decode→execute boundary. Tracks destination registers of up to `STAGES` in-flight instructions in an internal scoreboard and generates bypass selects itself, rather than taking them as inputs. Detects load-use hazards and inserts bubbles. Captures resolved ALU operands and store data into an output register behind a valid/ready handshake.

## Interface
- `XLEN`, 32: data width.
- `STAGES`, 4: tracked result stages. Stage 0 is execute (the output register), then memory, write and write-back.
- `LOAD_STAGE`, 2: first stage index at which a late (load) result is valid.
---
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_flush`  in  1  kill the instruction in the output register and drop the input.
- `i_valid`  in  1  decode offers an instruction.
- `o_ready`  out  1  stage accepts the instruction.
- `i_rs1`, `i_rs2`, `i_rd`  in  5 each  register indices.
- `i_rd_wr`  in  1  instruction writes `rd`.
- `i_late`  in  1  result available only from `LOAD_STAGE`.
- `i_rs1_val`, `i_rs2_val`  in  XLEN  register-file read data.
- `i_alu_op1_sel`  in  1  1 = PC.
- `i_alu_op2_sel`  in  1  1 = immediate.
- `i_pc`  in  XLEN-2  PC[XLEN-1:2].
- `i_imm`  in  XLEN  immediate.
- `i_stage_val`  in  STAGES*XLEN  result of stage k in slice [k*XLEN +: XLEN]. Slice 0 is the combinational execute result of the output register.
- `i_ready`  in  1  downstream pipeline advances this cycle.
- `o_valid`  out  1  output register holds an instruction.
- `o_op1`, `o_op2`  out  XLEN  ALU operands.
- `o_bp1`, `o_bp2`  out  XLEN  forwarded rs1/rs2 values (branch compare, store data).
- `o_rd`  out  5.
- `o_rd_wr`  out  1.
- `o_late`  out  1.
- `o_hazard`  out  1  load-use stall this cycle.

## Operation
- **Scoreboard.** Entry k holds {valid, rd, rd_wr, late} for stage k.
  - Entry 0 is the output register itself.
  - Entries 1..STAGES-1 are a shift register.
  - On `i_ready`, entry k loads entry k-1.
  - Entry 1 loads the output register's fields, with valid = `o_valid`.
- **Match.** Entry k matches rsN when: valid, rd_wr, rd ≠ 0 and rd == rsN.
- **Forward priority.** The lowest matching k (youngest) wins.
  - No match: use the register-file value.
  - rsN = 0: value is 0, no match and no hazard.
- **Hazard.** Asserted when the winning match has late = 1 and k < LATE_STAGE, for either source.
  - A source whose winning match is valid forwards normally, even if an older entry would be late.
  - A hazard holds the instruction in decode: it is not captured.
- **Operand select.** bpN = the forwarded value.
  - op1 = {i_pc, 2'b00} if `i_alu_op1_sel`, else bp1.
  - op2 = `i_imm` if `i_alu_op2_sel`, else bp2.
- **Handshake.**
  - `o_ready` = (!o_valid | i_ready) & !o_hazard & !i_flush.
  - Capture occurs when i_valid & o_ready.
  - If !o_valid | i_ready and no capture, `o_valid` goes 0 (bubble).
  - If !i_ready and o_valid, the output register holds.
- **Flush.**
  - `o_valid` goes 0 next cycle and no capture occurs that cycle.
  - Entries 1..STAGES-1 still shift on `i_ready`. The flushed instruction shifts in as valid if `i_ready` is 1 that cycle (it is older than the flush source).
- **Reset.**
  - All scoreboard valids = 0 and `o_valid` = 0.
  - `o_op1`, `o_op2`, `o_bp1`, `o_bp2` = 0.
  - `o_rd` = 0, `o_rd_wr` = 0, `o_late` = 0.
  - `o_hazard` is combinational and reads 0 during reset because all entries are invalid.
  - Reset has priority over flush.

## Timing
- Capture latency is 1 cycle: operands appear on `o_*` the cycle after the handshake.
- Forward selection and hazard detection are combinational on current inputs and scoreboard. `o_hazard` and `o_ready` are combinational.
- A back-to-back ALU dependency uses slice 0 with no stall.
- A load dependency at distance 1 stalls for `LOAD_STAGE` cycles with `i_ready` = 1.
- A downstream stall (`i_ready` = 0) freezes the scoreboard. A pending hazard persists until the load reaches `LOAD_STAGE`.
- Simultaneous `i_flush` and `i_valid`: input not accepted. Decode must re-present it.

## Test plan
- **ALU chain, no stall.** addi x5 (result 0x10) then add x6,x5,x5 with `i_ready`=1 → second capture takes slice 0; `o_op1`=`o_op2`=0x10; `o_hazard` never 1.
- **Load-use.** lw x7 (late) then add x8,x7,x0, `LOAD_STAGE`=2 → `o_hazard`=1 for 2 cycles, then capture with `o_bp1` = slice 2 value 0xDEADBEEF; `o_op2`=0.
- **Priority and x0.** x9 written at stages 1 and 3 with values 1 and 3 → op1 = 1. rs1 = x0 with entry rd = 0 → op1 = 0.
- **PC/imm select.** `i_pc`=0x100 (byte 0x400), both sels = 1, `i_imm`=0x24 → `o_op1`=0x400, `o_op2`=0x24, `o_bp2` = forwarded rs2.
- **Downstream stall then flush.** `i_ready`=0 for 3 cycles → outputs and scoreboard frozen. Then `i_flush` with `i_ready`=1 → `o_valid`=0 next cycle and entry 1 holds the flushed instruction's rd.
- **Reset mid-hazard.** Assert `i_reset` while `o_hazard`=1 → next cycle all outputs 0 and `o_hazard`=0; the same `i_valid` instruction is accepted the cycle after reset releases.
